// File: rtl/sram_acc_if.sv
// Request/response bundle for the sram_acc accumulator SRAM.
// The requester side uses the master modport; the memory uses the slave modport.
interface sram_acc_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              ovf;

  modport master (
    output req_valid, req_op, req_addr, req_data,
    input  req_ready, rd_valid, rd_data, busy, ovf
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data,
    output req_ready, rd_valid, rd_data, busy, ovf
  );
endinterface

// File: rtl/sram_acc.sv
// Accumulator SRAM: read / write / signed accumulate / clear-all behind a valid-ready port.
// Define SRAM_ACC_SAT_EN to make accumulate saturate instead of wrapping.
module sram_acc #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic       rpll_clk,
  input logic       rst,
  sram_acc_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam bit                POW2      = (DEPTH == (1 << ADDR_W));

  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

`ifdef SRAM_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Reduce a one-bit-wider sum back to DATA_W, clamping on overflow when saturation is built in.
  function automatic logic signed [DATA_W-1:0] acc_result(input logic signed [DATA_W:0] s);
    logic ov;
    ov = s[DATA_W] ^ s[DATA_W-1];
    if (SAT_EN && ov) return s[DATA_W] ? SMIN : SMAX;
    return s[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;

  logic accept_p0;
  logic in_range_p0;
  logic hit_p0;

  logic                     rd_vld_p1;
  logic                     acc_vld_p1;
  logic                     wr_vld_p1;
  logic                     oor_p1;
  logic                     byp_p1;
  logic [ADDR_W-1:0]        addr_p1;
  logic signed [DATA_W-1:0] data_p1;
  logic signed [DATA_W-1:0] mem_q_p1;
  logic signed [DATA_W-1:0] byp_data_p1;

  logic signed [DATA_W-1:0] old_p1;
  logic signed [DATA_W:0]   sum_p1;
  logic signed [DATA_W-1:0] wdata_p1;
  logic                     ovf_p1;
  logic [DATA_W-1:0]        rd_data_c;
  logic [DATA_W-1:0]        rd_hold;

  generate
    if (POW2) begin : g_full
      assign in_range_p0 = 1'b1;
    end else begin : g_partial
      assign in_range_p0 = ({1'b0, bus.req_addr} < DEPTH_L);
    end
  endgenerate

  // ---- stage p0: request accept, bypass detect against pending stage-1 write
  always_comb begin
    accept_p0 = bus.req_valid && bus.req_ready;
    hit_p0    = wr_vld_p1 && (addr_p1 == bus.req_addr);
  end

  always_ff @(posedge rpll_clk) begin
    if (rst) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      rd_vld_p1  <= 1'b0;
      acc_vld_p1 <= 1'b0;
      wr_vld_p1  <= 1'b0;
      rd_hold    <= '0;
    end else begin
      rd_vld_p1  <= accept_p0 && (bus.req_op == OP_RD);
      acc_vld_p1 <= accept_p0 && (bus.req_op == OP_ACC) && in_range_p0;
      wr_vld_p1  <= accept_p0 && ((bus.req_op == OP_WR) || (bus.req_op == OP_ACC)) && in_range_p0;
      rd_hold    <= rd_data_c;
      case (state)
        IDLE: begin
          if (accept_p0 && (bus.req_op == OP_CLR)) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Synchronous read port; bypass data is captured alongside so the mux sits after the RAM.
  always_ff @(posedge rpll_clk) begin
    addr_p1     <= bus.req_addr;
    data_p1     <= bus.req_data;
    mem_q_p1    <= mem[bus.req_addr];
    byp_p1      <= hit_p0;
    byp_data_p1 <= wdata_p1;
    oor_p1      <= !in_range_p0;
  end

  // ---- stage p1: accumulate, read response, and the single memory write port
  always_comb begin
    old_p1    = byp_p1 ? byp_data_p1 : mem_q_p1;
    sum_p1    = $signed({old_p1[DATA_W-1], old_p1}) + $signed({data_p1[DATA_W-1], data_p1});
    ovf_p1    = acc_vld_p1 && (sum_p1[DATA_W] ^ sum_p1[DATA_W-1]);
    wdata_p1  = acc_vld_p1 ? acc_result(sum_p1) : data_p1;
    rd_data_c = rd_hold;
    if (rd_vld_p1) rd_data_c = oor_p1 ? '0 : old_p1;
  end

  always_ff @(posedge rpll_clk) begin
    if (!rst) begin
      if (state == CLEAR)  mem[clr_cnt] <= '0;
      else if (wr_vld_p1)  mem[addr_p1] <= wdata_p1;
    end
  end

  assign bus.req_ready = !rst && (state == IDLE);
  assign bus.busy      = !rst && (state == CLEAR);
  assign bus.rd_valid  = !rst && rd_vld_p1;
  assign bus.ovf       = !rst && ovf_p1;
  assign bus.rd_data   = rst ? '0 : rd_data_c;

endmodule

// File: tb/tb_sram_acc.sv
// Directed bench for sram_acc: an 8-bit x 1024 instance and a 16-bit x 600 instance.
// Expected values depend on whether SRAM_ACC_SAT_EN is defined for the build.
module tb_sram_acc;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic rpll_clk = 1'b0;
  logic rst      = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  always #5 rpll_clk = ~rpll_clk;

  sram_acc_if #(.DATA_W(8),  .ADDR_W(10)) b8  ();
  sram_acc_if #(.DATA_W(16), .ADDR_W(10)) b16 ();

  sram_acc u8 (
    .rpll_clk (rpll_clk),
    .rst      (rst),
    .bus      (b8.slave)
  );

  sram_acc #(.DATA_W(16), .DEPTH(600)) u16 (
    .rpll_clk (rpll_clk),
    .rst      (rst),
    .bus      (b16.slave)
  );

  task automatic tick();
    @(posedge rpll_clk);
    #1;
  endtask

  task automatic req8(input logic [1:0] op, input logic [9:0] a, input logic [7:0] d);
    b8.req_valid = 1'b1;
    b8.req_op    = op;
    b8.req_addr  = a;
    b8.req_data  = d;
    tick();
    b8.req_valid = 1'b0;
  endtask

  task automatic req16(input logic [1:0] op, input logic [9:0] a, input logic [15:0] d);
    b16.req_valid = 1'b1;
    b16.req_op    = op;
    b16.req_addr  = a;
    b16.req_data  = d;
    tick();
    b16.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (b8.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", b8.req_ready); end
    checks++;
    if (b8.busy !== 1'b0 || b8.rd_valid !== 1'b0 || b8.ovf !== 1'b0 || b8.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rd_valid=%b ovf=%b rd_data=%h want all 0",
               b8.busy, b8.rd_valid, b8.ovf, b8.rd_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (b8.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", b8.req_ready); end
    // a request presented while reset is high must not be taken, and memory survives reset
    req8(OP_WR, 10'd20, 8'h11);
    tick();
    tick();
    rst = 1'b1;
    b8.req_valid = 1'b1;
    b8.req_op    = OP_WR;
    b8.req_addr  = 10'd20;
    b8.req_data  = 8'h77;
    tick();
    b8.req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    req8(OP_RD, 10'd20, 8'h00);
    checks++;
    if (b8.rd_valid !== 1'b1 || b8.rd_data !== 8'h11) begin
      errors++;
      $display("FAIL reset_wins: rd_valid=%b rd_data=%h want 1/11", b8.rd_valid, b8.rd_data);
    end
    tick();
  endtask

  task automatic test_write_read();
    logic [9:0] a;
    logic [7:0] d;
    int         bad;
    req8(OP_WR, 10'd5, 8'hA5);
    req8(OP_RD, 10'd5, 8'h00);
    checks++;
    if (b8.rd_valid !== 1'b1 || b8.rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL raw_bypass: rd_valid=%b rd_data=%h want 1/a5", b8.rd_valid, b8.rd_data);
    end
    tick();
    checks++;
    if (b8.rd_valid !== 1'b0 || b8.rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL rd_hold: rd_valid=%b rd_data=%h want 0/a5", b8.rd_valid, b8.rd_data);
    end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 10'($urandom_range(1023, 0));
      d = 8'($urandom);
      req8(OP_WR, a, d);
      if (i % 2 == 1) tick();
      req8(OP_RD, a, 8'h00);
      checks++;
      if (b8.rd_valid !== 1'b1 || b8.rd_data !== d) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL random_rw[%0d]: addr=%0d rd_valid=%b rd_data=%h want 1/%h",
                   i, a, b8.rd_valid, b8.rd_data, d);
      end
      tick();
    end
  endtask

  task automatic test_accumulate_chain();
    int ovf_seen;
    ovf_seen = 0;
    req8(OP_WR, 10'd3, 8'd10);
    for (int i = 0; i < 4; i++) begin
      req8(OP_ACC, 10'd3, 8'd5);
      if (b8.ovf !== 1'b0) ovf_seen++;
      checks++;
      if (b8.rd_valid !== 1'b0) begin errors++; $display("FAIL acc_no_rd[%0d]: rd_valid=%b want 0", i, b8.rd_valid); end
    end
    req8(OP_RD, 10'd3, 8'h00);
    checks++;
    if (b8.rd_valid !== 1'b1 || b8.rd_data !== 8'd30) begin
      errors++;
      $display("FAIL acc_chain: rd_valid=%b rd_data=%0d want 1/30", b8.rd_valid, b8.rd_data);
    end
    checks++;
    if (ovf_seen !== 0) begin errors++; $display("FAIL acc_chain_ovf: pulses=%0d want 0", ovf_seen); end
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_pos;
    logic [7:0] exp_neg;
`ifdef SRAM_ACC_SAT_EN
    exp_pos = 8'h7F;
    exp_neg = 8'h80;
`else
    exp_pos = 8'h82;
    exp_neg = 8'h7E;
`endif
    req8(OP_WR, 10'd7, 8'd120);
    tick();
    req8(OP_ACC, 10'd7, 8'd10);
    checks++;
    if (b8.ovf !== 1'b1) begin errors++; $display("FAIL ovf_pos_pulse: got %b want 1", b8.ovf); end
    tick();
    checks++;
    if (b8.ovf !== 1'b0) begin errors++; $display("FAIL ovf_pos_single: got %b want 0", b8.ovf); end
    req8(OP_RD, 10'd7, 8'h00);
    checks++;
    if (b8.rd_data !== exp_pos) begin errors++; $display("FAIL ovf_pos_value: got %h want %h", b8.rd_data, exp_pos); end
    req8(OP_WR, 10'd8, 8'h88);
    req8(OP_ACC, 10'd8, 8'hF6);
    checks++;
    if (b8.ovf !== 1'b1) begin errors++; $display("FAIL ovf_neg_pulse: got %b want 1", b8.ovf); end
    req8(OP_RD, 10'd8, 8'h00);
    checks++;
    if (b8.rd_data !== exp_neg || b8.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_neg_value: rd_data=%h ovf=%b want %h/0", b8.rd_data, b8.ovf, exp_neg);
    end
    // landing exactly on the maximum is not an overflow
    req8(OP_WR, 10'd9, 8'd100);
    req8(OP_ACC, 10'd9, 8'd27);
    checks++;
    if (b8.ovf !== 1'b0) begin errors++; $display("FAIL ovf_edge_pulse: got %b want 0", b8.ovf); end
    req8(OP_RD, 10'd9, 8'h00);
    checks++;
    if (b8.rd_data !== 8'd127) begin errors++; $display("FAIL ovf_edge_value: got %h want 7f", b8.rd_data); end
    tick();
  endtask

  task automatic test_clear();
    logic [9:0] addrs [8];
    int         n;
    int         ready_bad;
    logic [7:0] want;
    addrs = '{10'd0, 10'd1, 10'd2, 10'd100, 10'd511, 10'd512, 10'd1000, 10'd1023};
    for (int i = 0; i < 8; i++) req8(OP_WR, addrs[i], 8'(8'h30 + i));
    req8(OP_CLR, 10'd0, 8'h00);
    // requester holds a write for the whole sweep; it must land only after the clear
    b8.req_valid = 1'b1;
    b8.req_op    = OP_WR;
    b8.req_addr  = 10'd2;
    b8.req_data  = 8'h55;
    n = 0;
    ready_bad = 0;
    while (b8.busy === 1'b1 && n < 1100) begin
      if (b8.req_ready !== 1'b0) ready_bad++;
      n++;
      tick();
    end
    checks++;
    if (n !== 1024) begin errors++; $display("FAIL clear_busy_len: got %0d cycles want 1024", n); end
    checks++;
    if (ready_bad !== 0) begin errors++; $display("FAIL clear_ready_low: ready high in %0d busy cycles want 0", ready_bad); end
    checks++;
    if (b8.req_ready !== 1'b1) begin errors++; $display("FAIL clear_ready_back: got %b want 1", b8.req_ready); end
    tick();
    b8.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      want = (addrs[i] == 10'd2) ? 8'h55 : 8'h00;
      req8(OP_RD, addrs[i], 8'h00);
      checks++;
      if (b8.rd_valid !== 1'b1 || b8.rd_data !== want) begin
        errors++;
        $display("FAIL clear_readback[%0d]: rd_valid=%b rd_data=%h want 1/%h", addrs[i], b8.rd_valid, b8.rd_data, want);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    logic [9:0] probe [6];
    logic [7:0] want;
    probe = '{10'd0, 10'd8, 10'd9, 10'd10, 10'd500, 10'd1023};
    for (int i = 0; i < 1024; i++) req8(OP_WR, 10'(i), 8'hFF);
    tick();
    req8(OP_CLR, 10'd0, 8'h00);
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (b8.busy !== 1'b1) begin errors++; $display("FAIL midclear_busy: got %b want 1", b8.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (b8.busy !== 1'b0 || b8.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midclear_idle: busy=%b req_ready=%b want 0/1", b8.busy, b8.req_ready);
    end
    for (int i = 0; i < 6; i++) begin
      want = (probe[i] <= 10'd8) ? 8'h00 : 8'hFF;
      req8(OP_RD, probe[i], 8'h00);
      checks++;
      if (b8.rd_valid !== 1'b1 || b8.rd_data !== want) begin
        errors++;
        $display("FAIL midclear_read[%0d]: rd_valid=%b rd_data=%h want 1/%h", probe[i], b8.rd_valid, b8.rd_data, want);
      end
    end
    tick();
  endtask

  task automatic test_param16();
    logic [15:0] exp_sum;
`ifdef SRAM_ACC_SAT_EN
    exp_sum = 16'h7FFF;
`else
    exp_sum = 16'h8010;
`endif
    req16(OP_WR, 10'd4, 16'h7FF0);
    req16(OP_ACC, 10'd4, 16'h0020);
    checks++;
    if (b16.ovf !== 1'b1) begin errors++; $display("FAIL p16_ovf: got %b want 1", b16.ovf); end
    req16(OP_RD, 10'd4, 16'h0000);
    checks++;
    if (b16.rd_valid !== 1'b1 || b16.rd_data !== exp_sum) begin
      errors++;
      $display("FAIL p16_acc: rd_valid=%b rd_data=%h want 1/%h", b16.rd_valid, b16.rd_data, exp_sum);
    end
    req16(OP_WR, 10'd599, 16'hBEEF);
    req16(OP_WR, 10'd700, 16'h1234);
    req16(OP_ACC, 10'd700, 16'h7FFF);
    checks++;
    if (b16.ovf !== 1'b0) begin errors++; $display("FAIL p16_oor_ovf: got %b want 0", b16.ovf); end
    tick();
    req16(OP_RD, 10'd599, 16'h0000);
    checks++;
    if (b16.rd_valid !== 1'b1 || b16.rd_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL p16_last: rd_valid=%b rd_data=%h want 1/beef", b16.rd_valid, b16.rd_data);
    end
    req16(OP_RD, 10'd700, 16'h0000);
    checks++;
    if (b16.rd_valid !== 1'b1 || b16.rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL p16_oor_read: rd_valid=%b rd_data=%h want 1/0000", b16.rd_valid, b16.rd_data);
    end
    tick();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    b8.req_valid  = 1'b0;
    b8.req_op     = OP_RD;
    b8.req_addr   = '0;
    b8.req_data   = '0;
    b16.req_valid = 1'b0;
    b16.req_op    = OP_RD;
    b16.req_addr  = '0;
    b16.req_data  = '0;
    test_reset();
    test_write_read();
    test_accumulate_chain();
    test_overflow();
    test_clear();
    test_reset_mid_clear();
    test_param16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_acc.md
Name: sram_acc

Overview:
Parametrised accumulator SRAM, next generation of the fixed 8-bit x 1024 result SRAMs in the NPU datapath. Single clock domain on rpll_clk. Supports read, write, signed read-modify-write accumulate and a whole-array clear sweep. All ops go through a valid/ready request port, and a one-stage write pipeline with bypass allows back-to-back accesses to the same address. Sits between the MAC array output and the result readout logic.

Parameters:
DATA_W, 8, word width in bits; two's-complement signed for accumulate
DEPTH, 1024, number of words; any value >= 2
ADDR_W, $clog2(DEPTH), address width in bits

Ports:
rpll_clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_op  in  2  00 read, 01 write, 10 accumulate, 11 clear-all
req_addr  in  ADDR_W  word address
req_data  in  DATA_W  write data or addend
rd_valid  out  1  rd_data valid (1-cycle pulse)
rd_data  out  DATA_W  read result
busy  out  1  clear sweep in progress
ovf  out  1  1-cycle pulse: accumulate overflowed

Behaviour:
- Interface: one clock (rpll_clk); reset rst is synchronous and active-high.
- Accept: a request is taken on a rising edge E_k when req_valid && req_ready.
- Reset: all outputs are 0 during reset. req_ready is 1 from the first cycle after rst deasserts. Stage-1 and the FSM are cleared. Memory contents are not touched.
- Memory: 1 write port and 1 synchronous read port.
- Stage-1 register holds {wr_en, addr, wdata}.
  - Read and accumulate sample the old word at E_k.
  - Write and accumulate load stage-1 at E_k; the memory write occurs at E_{k+1}.
- Bypass: if a request at E_{k+1} targets the address pending in stage-1, it uses the stage-1 wdata instead of the memory output. This makes read-after-write and accumulate chains exact at full rate.
- Read: rd_valid=1 and rd_data=word in the cycle after E_k. Otherwise rd_valid=0 and rd_data holds its last value.
- Write: memory[addr] = req_data, visible to any request from E_{k+1} on.
- Accumulate: new = old + req_data, DATA_W-bit signed arithmetic. Computed from the E_k sample or bypass, then written via stage-1. No read response.
- ovf: asserts 1 cycle after E_k when signed overflow occurs (operands of the same sign, result of the opposite sign).
- Throughput: one op per cycle with no stalls, except clear.
- Address range: addr >= DEPTH (non-power-of-2 DEPTH only).
  - Write/accumulate are dropped.
  - Read returns 0 with rd_valid=1.
  - ovf stays 0.
- FSM: IDLE -> CLEAR on an accepted clear-all at E_k. Stage-1 loads a no-op at E_k; the earlier pending write completes at E_k.
  - CLEAR writes 0 to addr 0..DEPTH-1, one per edge, E_{k+1}..E_{k+DEPTH}, then returns to IDLE.
  - busy=1 and req_ready=0 from the cycle after E_k through the cycle ending at E_{k+DEPTH}.
  - The next accept is possible at E_{k+DEPTH+1}.
  - req_valid during CLEAR is ignored; the requester holds its request.
- Reset mid-clear: the FSM returns to IDLE immediately, busy=0, and memory is left partially cleared.
- Simultaneous reset and request: reset wins and the request is not accepted.

Optional Feature:
SRAM_ACC_SAT_EN:
- Defined: accumulate saturates. Positive overflow writes 2^(DATA_W-1)-1; negative overflow writes -2^(DATA_W-1).
- Undefined: two's-complement wrap-around.
- ovf pulses on overflow in both builds.

Test Plan:
- Write/read-back: write addr 5 = 8'hA5, then read addr 5 next cycle -> rd_valid 1 cycle later, rd_data=8'hA5 (bypass path). Repeat 1000 random addr/data pairs with idle gaps -> all match.
- Accumulate chain: write addr 3 = 8'd10, then 4 back-to-back accumulates of +5 to addr 3, then read -> rd_data=8'd30, ovf never asserts.
- Overflow: write addr 7 = 8'd120, accumulate +10 -> ovf pulses once. Read gives 8'd127 with SRAM_ACC_SAT_EN, 8'h82 (-126) without. Negative case: -120 + -10 -> 8'h80 (sat) / 8'd126 (wrap).
- Clear: fill 8 addresses with non-zero values, issue clear-all -> busy=1 and req_ready=0 for exactly DEPTH cycles; afterwards reads of those addresses return 0.
- Reset mid-clear: assert rst 10 cycles into a clear with all words prefilled 8'hFF -> busy=0 next cycle. Addr 0..8 read 0, addr 9 and above read 8'hFF.
- Param sweep: DATA_W=16, DEPTH=600 -> accumulate 16'h7FF0 + 16'h0020 saturates or wraps correctly. Read of addr 700 returns 0 with rd_valid=1, and a write there is dropped.
